// File: rtl/ct_pair_loader_if.sv
// Handshake bundle between the coefficient source, the pair loader and the
// ciphertext consumer. A ciphertext is carried as [1:0][N_COEFF-1:0] words:
// index [0] is polynomial A and index [1] is polynomial B.
interface ct_pair_loader_if #(
  parameter int N_COEFF = 8,
  parameter int COEF_W  = 32
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [COEF_W-1:0]                     in_coef;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [1:0][N_COEFF-1:0][COEF_W-1:0]   out_ct1;
  logic [1:0][N_COEFF-1:0][COEF_W-1:0]   out_ct2;

  // Loader side.
  modport master (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_ct1, out_ct2
  );

  // Source/consumer side.
  modport slave (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_ct1, out_ct2
  );
endinterface

// File: rtl/ct_pair_loader.sv
// Two-bank ping-pong loader: assembles a ciphertext pair from a serial
// coefficient stream into one bank while the other bank is presented to the
// ciphertext adder. Beat k of a pair lands in word k of the write bank, so the
// bank layout is {ct2.B, ct2.A, ct1.B, ct1.A} from the top word down.
module ct_pair_loader #(
  parameter int          N_COEFF = 8,
  parameter int          COEF_W  = 32,
  parameter logic [31:0] Q_MOD   = 32'd65537
) (
  input  logic                              clk,
  input  logic                              reset,
  ct_pair_loader_if.master                  bus,
  output logic                              err_range,
  output logic [$clog2(4*N_COEFF)-1:0]      beat_idx
);

  localparam int BEATS = 4 * N_COEFF;
  localparam int IDX_W = $clog2(BEATS);
  localparam int CMP_W = (COEF_W > 32) ? COEF_W : 32;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  // Bank storage, one word per beat.
  logic [1:0][BEATS-1:0][COEF_W-1:0] mem;

  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full;
  logic [1:0] full_nxt;

  logic in_fire;
  logic out_fire;
  logic last_beat;
  logic coef_oor;

  // The write bank is busy only when it still holds an unconsumed pair,
  // which happens exactly when both banks are full.
  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_beat = (beat_idx == LAST_BEAT);

  // Widen both sides so the range check holds for any COEF_W.
  assign coef_oor = CMP_W'(bus.in_coef) >= CMP_W'(Q_MOD);

  // Output pair straight from the read bank; registered state only, so there
  // is no path from in_* to out_*.
  assign bus.out_ct1 = mem[rd_bank][2*N_COEFF-1:0];
  assign bus.out_ct2 = mem[rd_bank][BEATS-1:2*N_COEFF];

  // Bank occupancy: a completed load marks the write bank full, a consumer
  // handshake frees the read bank. Both can happen in one cycle because they
  // never address the same bank.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with a default assigned
    // first so every path drives full_nxt and no latch is inferred; clocked
    // blocks use non-blocking '<=' only.
    full_nxt = full;
    if (in_fire && last_beat) full_nxt[wr_bank] = 1'b1;
    if (out_fire)             full_nxt[rd_bank] = 1'b0;
  end

  // State register: bank pointers, occupancy, beat counter, storage and the
  // sticky range flag. Reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the banks are cleared on reset because the consumer is allowed
      // to observe out_ct1/out_ct2 as all zeros after reset; storage that is
      // never read before being written would not need this.
      mem       <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      beat_idx  <= '0;
      err_range <= 1'b0;
    end else begin
      full <= full_nxt;

      if (in_fire) begin
        mem[wr_bank][beat_idx] <= bus.in_coef;
        if (coef_oor) err_range <= 1'b1;
        if (last_beat) begin
          wr_bank  <= ~wr_bank;
          beat_idx <= '0;
        end else begin
          beat_idx <= beat_idx + IDX_W'(1);
        end
      end

      // The bank being released keeps its contents.
      if (out_fire) rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_ct_pair_loader.sv
// Randomized bench for ct_pair_loader. The reference model treats the loader
// as a two-deep queue of completed pairs fed by a list of accepted beats.
module tb_ct_pair_loader;

  localparam int          N     = 4;
  localparam int          W     = 32;
  localparam int          BEATS = 4 * N;
  localparam logic [31:0] Q     = 32'd65537;

  typedef logic [BEATS-1:0][W-1:0]  pair_t;
  typedef logic [1:0][N-1:0][W-1:0] ct_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err_range;
  logic [3:0] beat_idx;

  ct_pair_loader_if #(.N_COEFF(N), .COEF_W(W)) bus ();

  ct_pair_loader #(.N_COEFF(N), .COEF_W(W), .Q_MOD(Q)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_range (err_range),
    .beat_idx  (beat_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [W-1:0] src_q[$];    // beats still to be offered
  logic [W-1:0] part_q[$];   // beats accepted for the pair under construction
  pair_t        pairs_q[$];  // completed pairs awaiting the consumer (max 2)
  bit           err_m;
  int           cyc;
  int           hs_cyc[$];   // cycles on which a pair was handed over
  int           idle_pct;
  int           out_mode;    // 0: hold off, 1: always ready, 2: random

  function automatic ct_t ct_of(input pair_t p, input int which);
    ct_t r;
    for (int i = 0; i < N; i++) begin
      r[0][i] = p[which*2*N + i];
      r[1][i] = p[which*2*N + N + i];
    end
    return r;
  endfunction

  task automatic compare_outputs();
    check("in_ready",  bus.in_ready,  pairs_q.size() < 2);
    check("out_valid", bus.out_valid, pairs_q.size() > 0);
    check("err_range", err_range,     err_m);
    check("beat_idx",  beat_idx,      part_q.size());
    if (pairs_q.size() > 0) begin
      check("out_ct1", bus.out_ct1, ct_of(pairs_q[0], 0));
      check("out_ct2", bus.out_ct2, ct_of(pairs_q[0], 1));
    end
  endtask

  // One clock cycle: compare at the falling edge, drive, advance the model.
  task automatic step();
    bit           in_f;
    bit           out_f;
    logic [W-1:0] coef;
    logic [W-1:0] tmp;
    pair_t        done;
    compare_outputs();
    if (reset) begin
      bus.in_valid  = 1'b1;
      bus.in_coef   = $urandom;
      bus.out_ready = 1'b1;
    end else begin
      bus.in_valid = (src_q.size() > 0) && ($urandom_range(99) >= idle_pct);
      bus.in_coef  = bus.in_valid ? src_q[0] : $urandom;
      case (out_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(1));
      endcase
    end
    in_f  = !reset && bus.in_valid && (pairs_q.size() < 2);
    out_f = !reset && bus.out_ready && (pairs_q.size() > 0);
    coef  = bus.in_coef;
    @(posedge clk);
    if (reset) begin
      part_q.delete();
      pairs_q.delete();
      src_q.delete();
      err_m = 1'b0;
    end else begin
      if (out_f) begin
        done = pairs_q.pop_front();
        hs_cyc.push_back(cyc);
      end
      if (in_f) begin
        tmp = src_q.pop_front();
        if (coef >= Q) err_m = 1'b1;
        part_q.push_back(coef);
        if (part_q.size() == BEATS) begin
          for (int k = 0; k < BEATS; k++) done[k] = part_q[k];
          pairs_q.push_back(done);
          part_q.delete();
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() > 0 || pairs_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", (src_q.size() == 0) && (pairs_q.size() == 0), 1'b1);
  endtask

  task automatic push_seq(input int first);
    for (int k = 0; k < BEATS; k++) src_q.push_back(W'(first + k));
  endtask

  task automatic push_rand_pair();
    for (int k = 0; k < BEATS; k++) src_q.push_back(W'($urandom_range(65536)));
  endtask

  initial begin
    int start;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_coef   = '0;
    bus.out_ready = 1'b0;
    idle_pct = 0;
    out_mode = 1;
    err_m    = 1'b0;
    cyc      = 0;

    // Reset state.
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    check("reset_ct1", bus.out_ct1, '0);
    check("reset_ct2", bus.out_ct2, '0);
    step();

    // 1: single pair, continuous input, consumer always ready.
    out_mode = 1;
    hs_cyc.delete();
    start = cyc;
    push_seq(1);
    drain(100);
    check("s1_handshakes", hs_cyc.size(), 1);
    if (hs_cyc.size() == 1) check("s1_latency", hs_cyc[0] - start, BEATS);

    // 2: back-pressure across three pairs.
    out_mode = 0;
    push_seq(1001);
    push_seq(2001);
    push_seq(3001);
    repeat (40) step();
    check("s2_in_ready_low", bus.in_ready, 1'b0);
    out_mode = 1;
    step();
    out_mode = 0;
    check("s2_in_ready_back", bus.in_ready, 1'b1);
    check("s2_pair2_ct1", bus.out_ct1[0][0], 32'd2001);
    repeat (20) step();
    out_mode = 1;
    drain(200);

    // 3: random bubbles on the input, random consumer stalls.
    idle_pct = 30;
    out_mode = 2;
    push_seq(1);
    push_rand_pair();
    drain(400);
    idle_pct = 0;

    // 4: out-of-range coefficient on beat 7 (ct1.B[2]).
    out_mode = 0;
    for (int k = 0; k < BEATS; k++)
      src_q.push_back((k == 6) ? W'(65537) : W'($urandom_range(65536)));
    n = 0;
    while (pairs_q.size() == 0 && n < 100) begin
      step();
      n++;
    end
    check("s4_stored", bus.out_ct1[1][2], 32'd65537);
    check("s4_err", err_range, 1'b1);
    out_mode = 1;
    drain(100);
    repeat (3) step();

    // 5: reset while a pair is presented and another is half loaded.
    out_mode = 0;
    push_rand_pair();
    push_rand_pair();
    n = 0;
    while (!(part_q.size() == 10 && pairs_q.size() == 1) && n < 100) begin
      step();
      n++;
    end
    check("s5_pre_reset_beat", beat_idx, 4'd10);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("s5_ct1_cleared", bus.out_ct1, '0);
    check("s5_err_cleared", err_range, 1'b0);
    out_mode = 1;
    push_seq(101);
    drain(100);

    // 6: continuous traffic, final beat and handshake overlap.
    out_mode = 1;
    hs_cyc.delete();
    for (int p = 0; p < 4; p++) push_rand_pair();
    drain(200);
    check("s6_pairs", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4)
      for (int k = 1; k < 4; k++) check("s6_spacing", hs_cyc[k] - hs_cyc[k-1], BEATS);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ct_pair_loader.md
Name: ct_pair_loader

Overview:
- Upstream feeder for the ciphertext-ciphertext adder.
- Accepts a serial stream of coefficients over a valid/ready handshake and assembles two full ciphertexts (CT_t: polynomials A and B).
- Presents the completed pair in parallel as out_ct1/out_ct2 with a valid/ready handshake.
- Two-bank ping-pong buffer: the next pair loads while the current pair is held for the consumer.

Parameters:
- N_COEFF, default 8: coefficients per polynomial. Must equal the polynomial length of CT_t in types.svh.
- COEF_W, default 32: bits per coefficient. Must equal the CT_t element width.
- Q_MOD, default 32'd65537: ciphertext modulus, used only for the input range check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_coef carries a coefficient.
- in_ready  out  1  loader accepts in_coef this cycle.
- in_coef  in  COEF_W  coefficient, unsigned.
- out_valid  out  1  out_ct1/out_ct2 hold a complete pair.
- out_ready  in  1  consumer takes the pair this cycle.
- out_ct1  out  CT_t  first ciphertext of the pair.
- out_ct2  out  CT_t  second ciphertext of the pair.
- err_range  out  1  sticky flag: some accepted coefficient was >= Q_MOD.
- beat_idx  out  $clog2(4*N_COEFF)  index of the next beat to be written into the write bank (debug).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - wr_bank=0, rd_bank=0, full[1:0]=0, beat_idx=0.
  - out_valid=0, in_ready=1, err_range=0.
  - Both banks cleared to zero, so out_ct1/out_ct2 read all zeros.
- Beat order within one pair (4*N_COEFF beats), with i = 0..N_COEFF-1 and i=0 first in each group:
  - beats 0..N-1 -> ct1.A[i]
  - beats N..2N-1 -> ct1.B[i]
  - beats 2N..3N-1 -> ct2.A[i]
  - beats 3N..4N-1 -> ct2.B[i]
- Input handshake:
  - in_ready = !full[wr_bank].
  - Accept when in_valid && in_ready: write in_coef into bank wr_bank at beat_idx, then beat_idx++.
  - Accepting beat 4N-1: set full[wr_bank], toggle wr_bank, beat_idx wraps to 0 (no 4N value is ever held).
  - in_valid low: no state change. Gaps are allowed anywhere in the sequence.
- Output handshake:
  - out_valid = full[rd_bank].
  - out_ct1/out_ct2 are read from bank rd_bank and stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear full[rd_bank] and toggle rd_bank. The bank keeps its contents; they are not cleared.
- Latency:
  - A pair becomes visible with out_valid=1 on the cycle after its last beat is accepted. There is no combinational path from in_* to out_*.
  - in_ready on the cycle after an output handshake reflects the freed bank.
- Simultaneous events:
  - A final-beat write and an output handshake in the same cycle always target different banks; both take effect.
  - When wr_bank==rd_bank and that bank is full, in_ready=0, so a write cannot collide with a read.
- Throughput:
  - Both banks full: in_ready=0 until the consumer takes one pair.
  - With out_ready held high: sustained rate is one coefficient per cycle, and a pair is presented every 4N cycles.
- Range check:
  - An accepted beat with in_coef >= Q_MOD sets err_range. It stays set until reset.
  - The coefficient is stored unmodified; no reduction is applied.
- Reset mid-operation:
  - A partial pair is discarded, beat_idx returns to 0, and both banks become empty.
  - Any pair being presented is dropped (out_valid=0 the next cycle).
  - Reset has priority over any handshake in the same cycle.

Test Plan (N_COEFF=4 build override, Q_MOD=65537):
1. Single pair: stream 1..16 with in_valid held high and out_ready=1.
   -> out_valid rises the cycle after beat 16 and stays high one cycle.
   -> ct1.A={1,2,3,4}, ct1.B={5..8}, ct2.A={9..12}, ct2.B={13..16}.
2. Back-pressure: out_ready=0, stream three pairs continuously.
   -> in_ready drops after beat 32 and stays 0.
   -> out_ct holds pair 1 stable.
   -> Raise out_ready for 1 cycle: pair 2 appears next cycle and in_ready returns to 1.
3. Bubbles: random in_valid gaps with 30% idle cycles over 16 beats.
   -> Output identical to scenario 1; beat_idx advances only on accepted beats.
4. Range error: beat 7 = 65537, all other beats < Q_MOD.
   -> err_range=1 from the cycle after beat 7 and stays set.
   -> ct1.B[2]=65537 is stored unchanged.
5. Reset mid-load: assert reset after 10 beats, then stream a fresh pair 101..116.
   -> Presented pair is 101..116 only; err_range=0; out_valid=0 throughout reset.
6. Simultaneous events: out_ready=1 and continuous input across 4 pairs.
   -> Final beat of pair k+1 and the handshake of pair k coincide.
   -> in_ready never drops; pairs 1..4 emerge in order, 16 cycles apart.
